// File: rtl/fp_feeder_queue.sv
// fp_feeder_queue: bus front end feeding an in-order FP core, with a credit-limited result FIFO.
// Defining FP_FEEDER_PERF_CNT_EN adds the ISSUE_CNT and LAST_LAT counters.
module fp_feeder_queue #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = 32'hC4100000,
   parameter int FIFO_DEPTH = 4,
   parameter int OP_W = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] data_i,
   output logic            ready_o,
   output logic [XLEN-1:0] data_o,
   output logic            fp_valid_o,
   output logic [XLEN-1:0] fp_a_o,
   output logic [XLEN-1:0] fp_b_o,
   output logic [OP_W-1:0] fp_op_o,
   input  logic            fp_result_valid_i,
   input  logic [XLEN-1:0] fp_result_i
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [4:0] OFF_A = 5'h00, OFF_B = 5'h04, OFF_RES = 5'h08, OFF_OP = 5'h0C, OFF_ST = 5'h10;
   logic [XLEN-1:0] mem [FIFO_DEPTH];
   logic [XLEN-1:0] a_q, b_q, rdata, status, perf_rd;
   logic [OP_W-1:0] op_q;
   logic [AW:0]     wr_ptr, rd_ptr, cnt, inflight;
   logic [AW+1:0]   outst;
   logic [4:0]      off;
   logic hit, acc, empty, full, udf, spur;
   logic is_b, is_res, stall, done, issue, pop, push, wr_a, wr_op, wr_st;
   assign off    = addr_i[4:0];
   assign hit    = addr_i[XLEN-1:5] == BASE_ADDR[XLEN-1:5];
   assign acc    = en_i && !ready_o;
   assign cnt    = wr_ptr - rd_ptr;
   assign empty  = cnt == '0;
   assign full   = cnt == (AW+1)'(FIFO_DEPTH);
   assign outst  = {1'b0, inflight} + {1'b0, cnt};
   assign is_b   = hit && off == OFF_B;
   assign is_res = hit && off == OFF_RES;
   // B writes wait for a credit; RESULT reads wait only while a result is still on its way
   assign stall  = acc && (we_i ? is_b && outst >= (AW+2)'(FIFO_DEPTH) : is_res && empty && inflight != '0);
   assign done   = acc && !stall;
   assign issue  = done && we_i && is_b;
   assign pop    = done && !we_i && is_res && !empty;
   assign push   = fp_result_valid_i && inflight != '0;
   assign wr_a   = done && we_i && hit && off == OFF_A;
   assign wr_op  = done && we_i && hit && off == OFF_OP;
   assign wr_st  = done && we_i && hit && off == OFF_ST;
   assign status = XLEN'({8'(cnt), 3'b000, spur, udf, inflight != '0, full, empty});
   assign rdata  = !hit ? '0 :
                   off == OFF_A ? a_q :
                   off == OFF_B ? b_q :
                   off == OFF_RES ? (empty ? '0 : mem[rd_ptr[AW-1:0]]) :
                   off == OFF_OP ? XLEN'(op_q) :
                   off == OFF_ST ? status : perf_rd;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         ready_o    <= 1'b0;
         data_o     <= '0;
         fp_valid_o <= 1'b0;
         fp_a_o     <= '0;
         fp_b_o     <= '0;
         fp_op_o    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         inflight   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         udf        <= 1'b0;
         spur       <= 1'b0;
      end else begin
         ready_o    <= done;
         fp_valid_o <= issue;
         data_o     <= done && !we_i ? rdata : '0;
         if (wr_a) a_q <= data_i;
         if (wr_op) op_q <= data_i[OP_W-1:0];
         if (issue) begin
            b_q     <= data_i;
            fp_a_o  <= a_q;
            fp_b_o  <= data_i;
            fp_op_o <= op_q;
         end
         inflight <= inflight + (AW+1)'(issue) - (AW+1)'(push);
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         udf  <= (done && !we_i && is_res && empty) || (udf && !(wr_st && data_i[3]));
         spur <= (fp_result_valid_i && inflight == '0) || (spur && !(wr_st && data_i[4]));
      end
   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr[AW-1:0]] <= fp_result_i;
`ifdef FP_FEEDER_PERF_CNT_EN
   localparam logic [4:0] OFF_IC = 5'h14, OFF_LL = 5'h18;
   logic [31:0]   issue_cnt, last_lat;
   logic [31:0]   age [FIFO_DEPTH];
   logic [AW-1:0] is_slot, rs_slot;
   logic          clr;
   assign clr     = done && we_i && hit && off == OFF_IC;
   assign perf_rd = off == OFF_IC ? XLEN'(issue_cnt) : off == OFF_LL ? XLEN'(last_lat) : '0;
   // one saturating age counter per in-flight op, allocated and retired in issue order
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         issue_cnt <= '0;
         last_lat  <= '0;
         is_slot   <= '0;
         rs_slot   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) age[i] <= age[i] + 32'(age[i] != '1);
         if (issue) begin
            age[is_slot] <= '0;
            is_slot      <= is_slot + AW'(1);
         end
         if (push) begin
            last_lat <= age[rs_slot];
            rs_slot  <= rs_slot + AW'(1);
         end
         if (clr) last_lat <= '0;
         issue_cnt <= clr ? '0 : issue_cnt + 32'(issue);
      end
`else
   assign perf_rd = '0;
`endif
endmodule
